// File: rtl/dac_spi_driver.sv
// dac_spi_driver: SPI mode-0 DAC writer with one-word pending buffer.
// Frames are SETUP, SHIFT (MSB first), HOLD, then a chip-select GAP.
module dac_spi_driver #(
  parameter int WIDTH    = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch_dac,
  input  logic [WIDTH-1:0] din,
  output logic             cs_dac,
  output logic             sclk_dac,
  output logic             sdo_dac,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CW = 16;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t           r_state, w_state_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [BW-1:0]    r_bit, w_bit_n;
  logic             r_ph, w_ph_n;
  logic [WIDTH-1:0] r_sr, w_sr_n;
  logic [WIDTH-1:0] r_pend_word;
  logic             r_pend;
  logic             r_cs, w_cs_n;
  logic             r_sclk, w_sclk_n;
  logic             r_sdo, w_sdo_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_ovr;
  logic             w_start;

  // next-state, counters and next registered output values
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_ph_n    = r_ph;
    w_sr_n    = r_sr;
    w_cs_n    = r_cs;
    w_sclk_n  = r_sclk;
    w_sdo_n   = r_sdo;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_start   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (r_pend || latch_dac) begin
          w_start   = 1'b1;
          w_state_n = SETUP;
          w_sr_n    = latch_dac ? din : r_pend_word;
          w_cs_n    = 1'b0;
          w_busy_n  = 1'b1;
          w_sdo_n   = w_sr_n[WIDTH-1];
        end
      end
      SETUP: begin
        if (r_cnt == CW'(CS_SETUP - 1)) begin
          w_state_n = SHIFT;
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_ph_n    = 1'b0;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(CLK_DIV - 1)) begin
          w_cnt_n  = '0;
          w_ph_n   = ~r_ph;
          w_sclk_n = ~r_ph;
          if (r_ph) begin
            if (r_bit == BW'(WIDTH - 1)) begin
              w_state_n = HOLD;
            end else begin
              w_bit_n = r_bit + 1'b1;
              w_sr_n  = r_sr << 1;
              w_sdo_n = w_sr_n[WIDTH-1];
            end
          end
        end
      end
      HOLD: begin
        if (r_cnt == CW'(CS_HOLD - 1)) begin
          w_state_n = GAP;
          w_cnt_n   = '0;
          w_cs_n    = 1'b1;
          w_sdo_n   = 1'b0;
          w_done_n  = 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == CW'(CS_GAP - 1)) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
          w_busy_n  = 1'b0;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // FSM state, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_ph    <= 1'b0;
      r_sr    <= '0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_ph    <= w_ph_n;
      r_sr    <= w_sr_n;
      r_cs    <= w_cs_n;
      r_sclk  <= w_sclk_n;
      r_sdo   <= w_sdo_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // pending word capture; a word not consumed in IDLE waits here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_word <= '0;
      r_ovr       <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_start) begin
        r_pend <= 1'b0;
      end else if (latch_dac) begin
        r_pend      <= 1'b1;
        r_pend_word <= din;
        r_ovr       <= r_pend;
      end
    end
  end

  assign cs_dac   = r_cs;
  assign sclk_dac = r_sclk;
  assign sdo_dac  = r_sdo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_ovr;

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: frame-level model of dac_spi_driver timing,
// directed vectors, multi-cycle corner cases and random latches.
module tb_dac_spi_driver;

  localparam int W   = 16;
  localparam int D   = 4;
  localparam int SU  = 2;
  localparam int HO  = 2;
  localparam int GP  = 4;
  localparam int LOW = SU + 2 * D * W + HO;

  logic         clk = 1'b0;
  logic         rst, latch_dac;
  logic [W-1:0] din;
  logic         cs_dac, sclk_dac, sdo_dac, busy, done, overrun;

  always #5 clk = ~clk;

  dac_spi_driver #(
    .WIDTH(W), .CLK_DIV(D), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)
  ) dut (
    .clk(clk), .rst(rst), .latch_dac(latch_dac), .din(din),
    .cs_dac(cs_dac), .sclk_dac(sclk_dac), .sdo_dac(sdo_dac),
    .busy(busy), .done(done), .overrun(overrun)
  );

  int tests = 0;
  int fails = 0;
  int t = 0;

  bit         m_act, m_pend, m_ov;
  int         m_s;
  logic [W-1:0] m_w, m_pw;

  logic [W-1:0] sh;
  int nbits, lowcnt, last_rise, dones, ovs;
  logic last_sclk, last_cs;
  logic [W-1:0] frames[$];
  int lows[$];
  int bitsq[$];
  int falls[$];

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] word;
    int           low;
    int           rises;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cycle %0d: got %0h expected %0h",
                 nm, t, act, exp);
    end
  endtask

  task automatic expect_now(output logic [4:0] e, output bit sc,
                            output logic se);
    int k;
    e  = {1'b1, 1'b0, 1'b0, 1'b0, m_ov};
    sc = 1'b1;
    se = 1'b0;
    if (m_act && t >= m_s && t - m_s < LOW + GP) begin
      k = t - m_s;
      e[4] = (k >= LOW);
      e[3] = (k >= SU && k < LOW - HO && ((k - SU) / D) % 2 == 1);
      e[2] = 1'b1;
      e[1] = (k == LOW);
      if (k < LOW - HO)
        se = m_w[W - 1 - ((k < SU) ? 0 : (k - SU) / (2 * D))];
      else if (k < LOW)
        sc = 1'b0;
    end
  endtask

  task automatic model_step(input logic r, input logic l,
                            input logic [W-1:0] d);
    bit idle;
    if (r) begin
      m_act = 0; m_pend = 0; m_ov = 0;
    end else begin
      idle = !m_act || (t >= m_s + LOW + GP);
      m_ov = 0;
      if (idle && (l || m_pend)) begin
        m_w = l ? d : m_pw;
        m_s = t + 1;
        m_act = 1;
        m_pend = 0;
      end else if (l) begin
        m_ov = m_pend;
        m_pend = 1;
        m_pw = d;
      end
    end
  endtask

  task automatic monitor();
    if (!cs_dac && last_cs) begin
      nbits = 0; lowcnt = 0; falls.push_back(t);
    end
    if (!cs_dac) lowcnt++;
    if (!cs_dac && sclk_dac && !last_sclk) begin
      sh = {sh[W-2:0], sdo_dac};
      nbits++;
      if (nbits > 1) chk("sclk_period", 32'(t - last_rise), 32'(2 * D));
      last_rise = t;
    end
    if (cs_dac && !last_cs) begin
      frames.push_back(sh); lows.push_back(lowcnt);
      bitsq.push_back(nbits);
    end
    if (done) dones++;
    if (overrun) ovs++;
    last_sclk = sclk_dac;
    last_cs = cs_dac;
  endtask

  task automatic cyc(input logic r, input logic l, input logic [W-1:0] d);
    logic [4:0] e;
    bit sc;
    logic se;
    @(negedge clk);
    expect_now(e, sc, se);
    chk("outs", 32'({cs_dac, sclk_dac, busy, done, overrun}), 32'(e));
    if (sc) chk("sdo", 32'(sdo_dac), 32'(se));
    monitor();
    rst = r; latch_dac = l; din = d;
    model_step(r, l, d);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic clr();
    frames.delete(); lows.delete(); bitsq.delete(); falls.delete();
    dones = 0; ovs = 0;
  endtask

  initial begin
    tbl[0] = '{16'h8001, 16'h8001, LOW, W};
    tbl[1] = '{16'hA5C3, 16'hA5C3, LOW, W};
    tbl[2] = '{16'h0000, 16'h0000, LOW, W};
    tbl[3] = '{16'hFFFF, 16'hFFFF, LOW, W};
    rst = 1'b1; latch_dac = 1'b0; din = '0;
    last_cs = 1'b1; last_sclk = 1'b0; sh = '0;
    nbits = 0; lowcnt = 0; last_rise = 0;
    m_act = 0; m_pend = 0; m_ov = 0; m_s = 0; m_w = '0; m_pw = '0;
    clr();
    repeat (3) @(posedge clk);
    cyc(1'b1, 1'b0, '0);
    idle(4);

    for (int i = 0; i < 4; i++) begin
      clr();
      cyc(1'b0, 1'b1, tbl[i].din);
      idle(300);
      chk("tbl_frames", 32'(frames.size()), 32'd1);
      chk("tbl_done", 32'(dones), 32'd1);
      chk("tbl_ovr", 32'(ovs), 32'd0);
      if (frames.size() > 0) begin
        chk("tbl_word", 32'(frames[0]), 32'(tbl[i].word));
        chk("tbl_low", 32'(lows[0]), 32'(tbl[i].low));
        chk("tbl_bits", 32'(bitsq[0]), 32'(tbl[i].rises));
      end
    end

    clr();
    cyc(1'b0, 1'b1, 16'h1111);
    idle(19);
    cyc(1'b0, 1'b1, 16'h2222);
    idle(330);
    chk("b2b_frames", 32'(frames.size()), 32'd2);
    chk("b2b_ovr", 32'(ovs), 32'd0);
    if (frames.size() == 2) begin
      chk("b2b_w0", 32'(frames[0]), 32'h1111);
      chk("b2b_w1", 32'(frames[1]), 32'h2222);
    end
    if (falls.size() == 2)
      chk("b2b_period", 32'(falls[1] - falls[0]), 32'(LOW + GP + 1));

    clr();
    cyc(1'b0, 1'b1, 16'h1111);
    idle(19);
    cyc(1'b0, 1'b1, 16'h2222);
    idle(19);
    cyc(1'b0, 1'b1, 16'h3333);
    idle(330);
    chk("ovr_cnt", 32'(ovs), 32'd1);
    chk("ovr_frames", 32'(frames.size()), 32'd2);
    if (frames.size() == 2) begin
      chk("ovr_w0", 32'(frames[0]), 32'h1111);
      chk("ovr_w1", 32'(frames[1]), 32'h3333);
    end

    clr();
    cyc(1'b0, 1'b1, 16'hC3A5);
    idle(61);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("rst_abort", 32'({cs_dac, sclk_dac, busy}), 32'b100);
    clr();
    cyc(1'b0, 1'b1, 16'h5A3C);
    idle(300);
    chk("rst_frames", 32'(frames.size()), 32'd1);
    if (frames.size() > 0) begin
      chk("rst_word", 32'(frames[0]), 32'h5A3C);
      chk("rst_bits", 32'(bitsq[0]), 32'(W));
    end

    clr();
    cyc(1'b1, 1'b1, 16'hBEEF);
    idle(200);
    chk("rst_latch_frames", 32'(falls.size()), 32'd0);

    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0, 799) == 0), ($urandom_range(0, 39) == 0),
          W'($urandom));
    idle(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
